// File: rtl/frame_sync_gate.sv
// rtl/frame_sync_gate.sv - multi-channel gate re-timing request/done onto VGA frame boundaries
// Each channel starts, stops and reports completion only at a VSYNC edge of the chosen polarity.
module frame_sync_gate #(
  parameter int NUM_CH     = 4,
  parameter int MIN_FRAMES = 1,
  parameter int VS_POL     = 1,
  parameter int FCW        = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_VGA_VSYNC,
  input  logic              i_flush,
  input  logic [NUM_CH-1:0] i_req,
  input  logic [NUM_CH-1:0] i_done,
  output logic [NUM_CH-1:0] o_active,
  output logic [NUM_CH-1:0] o_done,
  output logic              o_frame_tick,
  output logic [FCW-1:0]    o_frame_cnt
);

  localparam int             RCW     = $clog2(MIN_FRAMES + 1);
  localparam logic [RCW:0]   MIN_RUN = (RCW + 1)'(MIN_FRAMES);
  localparam logic [RCW-1:0] RUN_SAT = RCW'(MIN_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  logic vs;
  logic vs_d;
  logic tick;

  assign vs   = (VS_POL != 0) ? i_VGA_VSYNC : ~i_VGA_VSYNC;
  assign tick = vs & ~vs_d;

  // vs_d resets high so an already-active VSYNC at reset release is not a boundary
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vs_d         <= 1'b1;
      o_frame_tick <= 1'b0;
      o_frame_cnt  <= '0;
    end else begin
      vs_d         <= vs;
      o_frame_tick <= tick;
      if (tick) begin
        o_frame_cnt <= o_frame_cnt + 1'b1;
      end
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    state_t         state;
    logic [RCW-1:0] run_cnt;
    logic           done_pend;
    logic           active_q;
    logic           done_q;
    logic [RCW:0]   run_next;
    logic           run_done;

    assign run_next     = {1'b0, run_cnt} + 1'b1;
    assign run_done     = ~i_req[ch] && (run_next >= MIN_RUN);
    assign o_active[ch] = active_q;
    assign o_done[ch]   = done_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state     <= ST_IDLE;
        run_cnt   <= '0;
        done_pend <= 1'b0;
        active_q  <= 1'b0;
        done_q    <= 1'b0;
      end else if (i_flush) begin
        state     <= ST_IDLE;
        run_cnt   <= '0;
        done_pend <= 1'b0;
        active_q  <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_req[ch]) begin
              done_q    <= 1'b0;
              done_pend <= 1'b0;
              run_cnt   <= '0;
              if (tick) begin
                state    <= ST_RUN;
                active_q <= 1'b1;
              end else begin
                state <= ST_ARM;
              end
            end
          end
          // request is latched: a dropped i_req here still starts at the next boundary
          ST_ARM: begin
            if (tick) begin
              state    <= ST_RUN;
              active_q <= 1'b1;
              run_cnt  <= '0;
            end
          end
          ST_RUN: begin
            if (tick) begin
              if (done_pend || i_done[ch]) begin
                done_q <= 1'b1;
              end
              done_pend <= 1'b0;
              if (run_done) begin
                state    <= ST_IDLE;
                active_q <= 1'b0;
                run_cnt  <= '0;
              end else if (run_cnt != RUN_SAT) begin
                run_cnt <= run_cnt + 1'b1;
              end
            end else if (i_done[ch]) begin
              done_pend <= 1'b1;
            end
          end
          default: begin
            state    <= ST_IDLE;
            active_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_sync_gate.sv
// tb/tb_frame_sync_gate.sv - scoreboard bench for frame_sync_gate
// Two instances: A (1 ch, MIN_FRAMES=1, rising VSYNC, 16-bit count), B (4 ch, MIN_FRAMES=3, falling VSYNC, 4-bit count).
module tb_frame_sync_gate;

  localparam int FRAME = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync;
  logic        flush;
  logic [0:0]  req_a, done_a, act_a, dn_a;
  logic        tick_a;
  logic [15:0] cnt_a;
  logic [3:0]  req_b, done_b, act_b, dn_b;
  logic        tick_b;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  frame_sync_gate #(.NUM_CH(1), .MIN_FRAMES(1), .VS_POL(1), .FCW(16)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_VGA_VSYNC(vsync), .i_flush(flush),
    .i_req(req_a), .i_done(done_a), .o_active(act_a), .o_done(dn_a),
    .o_frame_tick(tick_a), .o_frame_cnt(cnt_a)
  );

  frame_sync_gate #(.NUM_CH(4), .MIN_FRAMES(3), .VS_POL(0), .FCW(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_VGA_VSYNC(vsync), .i_flush(flush),
    .i_req(req_b), .i_done(done_b), .o_active(act_b), .o_done(dn_b),
    .o_frame_tick(tick_b), .o_frame_cnt(cnt_b)
  );

  typedef struct {
    logic        a_act;
    logic        a_dn;
    logic        a_tick;
    logic [15:0] a_cnt;
    logic [3:0]  b_act;
    logic [3:0]  b_dn;
    logic        b_tick;
    logic [3:0]  b_cnt;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   vphase = 0;

  // reference model state, index [instance][channel]; state 0=idle 1=armed 2=running
  int NCH[2]  = '{1, 4};
  int MINF[2] = '{1, 3};
  int POL[2]  = '{1, 0};
  int CMOD[2] = '{65536, 16};
  int st[2][4];
  int frames[2][4];
  bit pend[2][4];
  bit act[2][4];
  bit dn[2][4];
  bit vsd[2];
  bit tq[2];
  int cnt[2];

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      vsd[m] = 1'b1;
      tq[m]  = 1'b0;
      cnt[m] = 0;
      for (int c = 0; c < 4; c++) begin
        st[m][c] = 0; frames[m][c] = 0; pend[m][c] = 0; act[m][c] = 0; dn[m][c] = 0;
      end
    end
  endtask

  task automatic model_step(input int m, input logic [3:0] rq, input logic [3:0] dq);
    bit vs, tk;
    vs = (POL[m] == 1) ? vsync : !vsync;
    tk = vs && !vsd[m];
    vsd[m] = vs;
    tq[m]  = tk;
    if (tk) cnt[m] = (cnt[m] + 1) % CMOD[m];
    for (int c = 0; c < NCH[m]; c++) begin
      if (flush) begin
        st[m][c] = 0; frames[m][c] = 0; pend[m][c] = 0; dn[m][c] = 0;
      end else if (st[m][c] == 0) begin
        if (rq[c]) begin
          dn[m][c] = 0; pend[m][c] = 0; frames[m][c] = 0;
          st[m][c] = tk ? 2 : 1;
        end
      end else if (st[m][c] == 1) begin
        if (tk) begin st[m][c] = 2; frames[m][c] = 0; end
      end else begin
        if (tk) begin
          if (pend[m][c] || dq[c]) dn[m][c] = 1;
          pend[m][c] = 0;
          // frames counts boundaries already completed in this run
          if (!rq[c] && frames[m][c] + 1 >= MINF[m]) begin
            st[m][c] = 0; frames[m][c] = 0;
          end else if (frames[m][c] < MINF[m]) begin
            frames[m][c]++;
          end
        end else if (dq[c]) begin
          pend[m][c] = 1;
        end
      end
      act[m][c] = (st[m][c] == 2);
    end
  endtask

  task automatic cycle();
    exp_t e, g;
    vsync = (vphase < 3);
    model_step(0, {3'b000, req_a}, {3'b000, done_a});
    model_step(1, req_b, done_b);
    e.a_act = act[0][0]; e.a_dn = dn[0][0]; e.a_tick = tq[0]; e.a_cnt = cnt[0][15:0];
    for (int c = 0; c < 4; c++) begin
      e.b_act[c] = act[1][c];
      e.b_dn[c]  = dn[1][c];
    end
    e.b_tick = tq[1]; e.b_cnt = cnt[1][3:0];
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    g = q.pop_front();
    expect_eq("a_active", {31'd0, act_a}, {31'd0, g.a_act});
    expect_eq("a_done", {31'd0, dn_a}, {31'd0, g.a_dn});
    expect_eq("a_tick", {31'd0, tick_a}, {31'd0, g.a_tick});
    expect_eq("a_cnt", {16'd0, cnt_a}, {16'd0, g.a_cnt});
    expect_eq("b_active", {28'd0, act_b}, {28'd0, g.b_act});
    expect_eq("b_done", {28'd0, dn_b}, {28'd0, g.b_dn});
    expect_eq("b_tick", {31'd0, tick_b}, {31'd0, g.b_tick});
    expect_eq("b_cnt", {28'd0, cnt_b}, {28'd0, g.b_cnt});
    vphase = (vphase + 1) % FRAME;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < FRAME && vphase != p; i++) cycle();
  endtask

  task automatic check_zero(input string tag);
    expect_eq({tag, "_a"}, {16'd0, cnt_a, 12'd0, tick_a, dn_a, act_a, 1'b0}, 32'd0);
    expect_eq({tag, "_b"}, {19'd0, cnt_b, tick_b, dn_b, act_b}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; vsync = 1'b1; flush = 1'b0;
    req_a = '0; done_a = '0; req_b = '0; done_b = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    vphase = 0;

    // VSYNC held high through release: no boundary on A until it falls and rises
    run(5);
    wait_phase(10); req_a = 1'b1; run(30);
    req_a = 1'b0; run(40);

    // request coincident with a boundary goes straight to running
    wait_phase(0); req_a = 1'b1; cycle(); run(25);
    req_a = 1'b0; run(25);

    // single-cycle request on B ch1 runs three whole frames
    wait_phase(10); req_b = 4'b0010; cycle(); req_b = 4'b0000; run(90);

    // completion mid-run, held through idle, cleared by next request
    req_b[0] = 1'b1; run(30);
    done_b[0] = 1'b1; cycle(); done_b = 4'b0000;
    req_b[0] = 1'b0; run(80);
    req_b[0] = 1'b1; cycle(); run(5); req_b[0] = 1'b0; run(70);

    // done while only armed is ignored
    wait_phase(5); req_b[3] = 1'b1; cycle();
    done_b[3] = 1'b1; cycle(); done_b = 4'b0000; req_b[3] = 1'b0; run(80);

    // staggered B requests plus A running, then a mid-frame flush
    wait_phase(8); req_b[0] = 1'b1; req_a = 1'b1; run(25);
    req_b[2] = 1'b1; done_b[2] = 1'b1; cycle(); done_b = 4'b0000; run(35);
    wait_phase(12); flush = 1'b1; cycle(); flush = 1'b0;
    expect_eq("flush_a_active", {31'd0, act_a}, 32'd0);
    expect_eq("flush_b_active", {28'd0, act_b}, 32'd0);
    expect_eq("flush_b_done", {28'd0, dn_b}, 32'd0);
    req_b = 4'b0000; run(30);

    // asynchronous reset while A is running
    run(45);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    req_a = '0; vsync = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; vphase = 0;
    run(10);

    // randomised traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) req_a = ~req_a;
      done_a = ($urandom_range(0, 11) == 0);
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 14) == 0) req_b[c] = ~req_b[c];
        done_b[c] = ($urandom_range(0, 11) == 0);
      end
      flush = ($urandom_range(0, 149) == 0);
      cycle();
    end
    req_a = '0; done_a = '0; req_b = '0; done_b = '0; flush = 1'b0;
    run(FRAME * 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
